// File: rtl/ntt_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ntt_mem_arbiter : round-robin share of one memory port among NUM_CORES
//                   engine DMA masters, with an ID FIFO to route read data.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ntt_mem_arbiter #(
  parameter int NUM_CORES       = 2,
  parameter int ADDR_W          = 48,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CORES-1:0]                  core_req,
  input  logic [NUM_CORES-1:0]                  core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]           core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]           core_wdata,
  output logic [NUM_CORES-1:0]                  core_gnt,
  output logic [NUM_CORES-1:0]                  core_valid,
  output logic [DATA_W-1:0]                     core_rdata,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [ADDR_W-1:0]                     mem_addr,
  output logic [DATA_W-1:0]                     mem_wdata,
  input  logic                                  mem_ready,
  input  logic                                  mem_rvalid,
  input  logic [DATA_W-1:0]                     mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  rd_outstanding,
  output logic                                  err_orphan
);

  localparam int ID_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      sel;
  logic                 found;
  int                   idx;
  logic [NUM_CORES-1:0] eligible;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [AW:0]          count;
  logic [ID_W-1:0]      id_mem [0:DEPTH-1];
  logic [ID_W-1:0]      head;

  // Reads need a free ID slot; writes never return data so they bypass the check.
  assign eligible = core_req & (core_we | {NUM_CORES{~fifo_full}});

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CORES;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  assign mem_req   = |eligible;
  assign mem_we    = mem_req ? core_we[sel] : 1'b0;
  assign mem_addr  = mem_req ? core_addr[sel*ADDR_W +: ADDR_W] : '0;
  assign mem_wdata = mem_req ? core_wdata[sel*DATA_W +: DATA_W] : '0;
  assign accept    = mem_req & mem_ready;
  assign push      = accept & ~mem_we;

  always_comb begin
    core_gnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (accept && (sel == ID_W'(i))) core_gnt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (sel == ID_W'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
    end
  end

  // ID FIFO: pointers carry an extra wrap bit so full and empty are distinct.
  assign count          = wr_ptr - rd_ptr;
  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_full      = (count == (AW+1)'(MAX_OUTSTANDING));
  assign rd_outstanding = count[CW-1:0];
  assign head           = id_mem[rd_ptr[AW-1:0]];
  assign pop            = mem_rvalid & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr[AW-1:0]] <= sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (mem_rvalid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  always_comb begin
    core_valid = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pop && (head == ID_W'(i))) core_valid[i] = 1'b1;
    end
  end

  assign core_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ntt_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ntt_mem_arbiter : directed self-checking bench for ntt_mem_arbiter
//                      (2 cores, 4-deep ID FIFO).
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ntt_mem_arbiter;

  localparam int NUM_CORES       = 2;
  localparam int ADDR_W          = 48;
  localparam int DATA_W          = 64;
  localparam int MAX_OUTSTANDING = 4;
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1);

  logic                          clk;
  logic                          rst_n;
  logic [NUM_CORES-1:0]          core_req;
  logic [NUM_CORES-1:0]          core_we;
  logic [NUM_CORES*ADDR_W-1:0]   core_addr;
  logic [NUM_CORES*DATA_W-1:0]   core_wdata;
  logic [NUM_CORES-1:0]          core_gnt;
  logic [NUM_CORES-1:0]          core_valid;
  logic [DATA_W-1:0]             core_rdata;
  logic                          mem_req;
  logic                          mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W-1:0]             mem_wdata;
  logic                          mem_ready;
  logic                          mem_rvalid;
  logic [DATA_W-1:0]             mem_rdata;
  logic [CW-1:0]                 rd_outstanding;
  logic                          err_orphan;

  int n_checks;
  int n_errors;

  ntt_mem_arbiter #(
    .NUM_CORES       (NUM_CORES),
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_req       (core_req),
    .core_we        (core_we),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_gnt       (core_gnt),
    .core_valid     (core_valid),
    .core_rdata     (core_rdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rd_outstanding (rd_outstanding),
    .err_orphan     (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled mid-low-phase.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    core_req   = '0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1;
    chk_val("rst_gnt", core_gnt, 0);
    chk_val("rst_valid", core_valid, 0);
    chk_val("rst_outst", rd_outstanding, 0);
    chk_val("rst_orphan", err_orphan, 0);
    chk_val("rst_mem_req", mem_req, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read by core0, response three cycles later.
    core_req = 2'b01; core_we = 2'b00; core_addr[0 +: ADDR_W] = 48'h1000;
    #1;
    chk_val("t1_gnt", core_gnt, 2'b01);
    chk_val("t1_addr", mem_addr, 64'h1000);
    chk_val("t1_we", mem_we, 0);
    step();
    core_req = 2'b00;
    #1;
    chk_val("t1_outst1", rd_outstanding, 1);
    step();
    step();
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
    #1;
    chk_val("t1_valid", core_valid, 2'b01);
    chk_val("t1_rdata", core_rdata, 64'hDEAD);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk_val("t1_outst0", rd_outstanding, 0);

    // rr_ptr now points at core1: core1 streams writes while core0 holds a read.
    core_req = 2'b11; core_we = 2'b10; core_addr[0 +: ADDR_W] = 48'h300;
    core_wdata[DATA_W +: DATA_W] = 64'h1111_0000;
    #1;
    chk_val("t3_gnt0", core_gnt, 2'b10);
    chk_val("t3_wd0", mem_wdata, 64'h1111_0000);
    chk_val("t3_we0", mem_we, 1);
    step();
    core_wdata[DATA_W +: DATA_W] = 64'h1111_0001;
    #1;
    chk_val("t3_gnt1", core_gnt, 2'b01);
    chk_val("t3_addr1", mem_addr, 64'h300);
    chk_val("t3_we1", mem_we, 0);
    step();
    core_req = 2'b10;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk_val("t3_gntw", core_gnt, 2'b10);
      chk_val("t3_wdw", mem_wdata, 64'h1111_0000 + 64'(k));
      step();
      core_wdata[DATA_W +: DATA_W] = 64'h1111_0001 + 64'(k);
    end
    core_req = 2'b00;
    #1;
    chk_val("t3_outst", rd_outstanding, 1);
    mem_rvalid = 1'b1; mem_rdata = 64'h3333;
    #1;
    chk_val("t3_valid", core_valid, 2'b01);
    step();
    mem_rvalid = 1'b0;

    // Fresh reset, then simultaneous reads from both cores.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    core_req = 2'b11; core_we = 2'b00;
    core_addr[0 +: ADDR_W] = 48'h100; core_addr[ADDR_W +: ADDR_W] = 48'h200;
    #1;
    chk_val("t2_gnt0", core_gnt, 2'b01);
    chk_val("t2_addr0", mem_addr, 64'h100);
    step();
    core_req = 2'b10;
    #1;
    chk_val("t2_gnt1", core_gnt, 2'b10);
    chk_val("t2_addr1", mem_addr, 64'h200);
    step();
    core_req = 2'b00;
    mem_rvalid = 1'b1; mem_rdata = 64'hAAAA;
    #1;
    chk_val("t2_validA", core_valid, 2'b01);
    chk_val("t2_rdataA", core_rdata, 64'hAAAA);
    step();
    mem_rdata = 64'hBBBB;
    #1;
    chk_val("t2_validB", core_valid, 2'b10);
    chk_val("t2_rdataB", core_rdata, 64'hBBBB);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk_val("t2_outst", rd_outstanding, 0);

    // Fill the ID FIFO, then show reads block while writes pass.
    core_req = 2'b01; core_we = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_val("t4_gnt_fill", core_gnt, 2'b01);
      step();
    end
    core_req = 2'b11; core_we = 2'b10;
    #1;
    chk_val("t4_outst4", rd_outstanding, 4);
    chk_val("t4_wr_pass", core_gnt, 2'b10);
    step();
    core_req = 2'b01;
    mem_rvalid = 1'b1; mem_rdata = 64'h4444;
    #1;
    chk_val("t4_blocked", core_gnt, 2'b00);
    chk_val("t4_valid", core_valid, 2'b01);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk_val("t4_unblock", core_gnt, 2'b01);
    step();
    core_req = 2'b00;
    #1;
    chk_val("t4_outst_again", rd_outstanding, 4);
    mem_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) step();
    mem_rvalid = 1'b0;
    #1;
    chk_val("t4_drained", rd_outstanding, 0);
    chk_val("t4_orphan", err_orphan, 0);

    // Backpressure: last accept was core0, so rr_ptr holds 1.
    mem_ready = 1'b0; core_req = 2'b01; core_we = 2'b00;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_val("t5_req", mem_req, 1);
      chk_val("t5_nognt", core_gnt, 2'b00);
      step();
    end
    chk_val("t5_rr", dut.rr_ptr, 1);
    mem_ready = 1'b1;
    #1;
    chk_val("t5_gnt", core_gnt, 2'b01);
    step();
    core_req = 2'b00;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk_val("t5_outst", rd_outstanding, 0);

    // Orphan responses and asynchronous reset.
    mem_rvalid = 1'b1; mem_rdata = 64'h6666;
    #1;
    chk_val("t6_valid", core_valid, 2'b00);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk_val("t6_orphan", err_orphan, 1);
    step();
    chk_val("t6_orphan_held", err_orphan, 1);
    core_req = 2'b01;
    step();
    step();
    core_req = 2'b00;
    #1;
    chk_val("t6_outst2", rd_outstanding, 2);
    rst_n = 1'b0;
    #1;
    chk_val("t6_async_outst", rd_outstanding, 0);
    chk_val("t6_async_orphan", err_orphan, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    #1;
    chk_val("t6_late_valid", core_valid, 2'b00);
    step();
    #1;
    chk_val("t6_late_orphan", err_orphan, 1);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk_val("t6_late_orphan2", err_orphan, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
